// File: rtl/proc_pkg.sv
// Shared processor definitions: trap sequencer states, CSR addresses,
// mstatus bit positions and the mstatus/redirect helper functions.
package proc_pkg;

    typedef enum logic [2:0] {
        TRAP_IDLE        = 3'd0,
        TRAP_WR_MEPC     = 3'd1,
        TRAP_WR_MCAUSE   = 3'd2,
        TRAP_WR_MTVAL    = 3'd3,
        TRAP_WR_MSTATUS  = 3'd4,
        TRAP_MRET_STATUS = 3'd5,
        TRAP_REDIRECT    = 3'd6
    } trap_state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRIV_M         = 2'b11;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // Registered output bundle of the trap sequencer.
    typedef struct packed {
        logic        wr_en;
        logic [11:0] wr_addr;
        logic [31:0] wr_data;
        logic        stall;
        logic        flush;
        logic        redirect_valid;
        logic [31:0] redirect_pc;
        logic        busy;
    } trap_out_t;

    function automatic logic [31:0] trap_entry_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

    // Vectored mode only applies to interrupts; the offset wraps at 32 bits.
    function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                                input logic [31:0] code);
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
        if (mtvec[1:0] == MTVEC_VECTORED && code[31]) begin
            return 32'(base + 32'({code[30:0], 2'b00}));
        end
        return base;
    endfunction

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// Fixed-priority encoder: the lowest-index asserted request wins.
module trap_prio_enc #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               any_valid,
    output logic [IDX_W-1:0]   sel_idx
);

    always_comb begin
        any_valid = |req;
        sel_idx   = '0;
        // Scan downwards so the lowest index is the last (winning) assignment.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exception requests, sequences the trap-entry and
// mret CSR writes through the single write port, then redirects fetch.
module trap_ctrl
    import proc_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_SRC-1:0]       exc_valid_i,
    input  logic [NUM_SRC-1:0][31:0] exc_code_i,
    input  logic [NUM_SRC-1:0][31:0] exc_pc_i,
    input  logic [NUM_SRC-1:0][31:0] exc_tval_i,
    input  logic                     mret_i,
    input  logic [31:0]              mstatus_i,
    input  logic [31:0]              mtvec_i,
    input  logic [31:0]              mepc_i,
    output logic                     csr_wr_en_o,
    output logic [11:0]              csr_wr_addr_o,
    output logic [31:0]              csr_wr_data_o,
    output logic                     stall_o,
    output logic                     flush_o,
    output logic                     redirect_valid_o,
    output logic [31:0]              redirect_pc_o,
    output logic                     busy_o,
    output trap_state_t              dbg_state_o
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    trap_state_t      state_q, state_d;
    logic [31:0]      code_q, pc_q, tval_q;
    logic [31:0]      code_d, pc_d, tval_d;
    trap_out_t        out_q, out_d;
    logic             any_valid;
    logic [IDX_W-1:0] sel_idx;

    trap_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_prio (
        .req       (exc_valid_i),
        .any_valid (any_valid),
        .sel_idx   (sel_idx)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= TRAP_IDLE;
            code_q  <= '0;
            pc_q    <= '0;
            tval_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pc_q    <= pc_d;
            tval_q  <= tval_d;
            out_q   <= out_d;
        end
    end

    // Requests have no ready signal: exc_valid_i / mret_i are taken only when
    // high during an IDLE cycle; while busy_o is high they are ignored, since
    // the pipeline is stalled and flushed and nothing it holds is live.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        pc_d    = pc_q;
        tval_d  = tval_q;
        case (state_q)
            TRAP_IDLE: begin
                if (any_valid) begin
                    state_d = TRAP_WR_MEPC;
                    code_d  = exc_code_i[sel_idx];
                    pc_d    = exc_pc_i[sel_idx];
                    tval_d  = exc_tval_i[sel_idx];
                end else if (mret_i) begin
                    state_d = TRAP_MRET_STATUS;
                end
            end
            TRAP_WR_MEPC:     state_d = TRAP_WR_MCAUSE;
            TRAP_WR_MCAUSE:   state_d = TRAP_WR_MTVAL;
            TRAP_WR_MTVAL:    state_d = TRAP_WR_MSTATUS;
            TRAP_WR_MSTATUS:  state_d = TRAP_REDIRECT;
            TRAP_MRET_STATUS: state_d = TRAP_REDIRECT;
            TRAP_REDIRECT:    state_d = TRAP_IDLE;
            default:          state_d = TRAP_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and loaded into out_q, so every
    // port is a flop that lines up with the state it describes.
    always_comb begin
        out_d       = '0;
        out_d.busy  = (state_d != TRAP_IDLE);
        out_d.stall = (state_d != TRAP_IDLE);
        out_d.flush = (state_d == TRAP_WR_MEPC) || (state_d == TRAP_MRET_STATUS);
        case (state_d)
            TRAP_WR_MEPC: begin
                out_d.wr_en   = 1'b1;
                out_d.wr_addr = CSR_MEPC;
                out_d.wr_data = {pc_d[31:2], 2'b00};
            end
            TRAP_WR_MCAUSE: begin
                out_d.wr_en   = 1'b1;
                out_d.wr_addr = CSR_MCAUSE;
                out_d.wr_data = code_d;
            end
            TRAP_WR_MTVAL: begin
                out_d.wr_en   = 1'b1;
                out_d.wr_addr = CSR_MTVAL;
                out_d.wr_data = tval_d;
            end
            TRAP_WR_MSTATUS: begin
                out_d.wr_en   = 1'b1;
                out_d.wr_addr = CSR_MSTATUS;
                out_d.wr_data = trap_entry_mstatus(mstatus_i);
            end
            TRAP_MRET_STATUS: begin
                out_d.wr_en   = 1'b1;
                out_d.wr_addr = CSR_MSTATUS;
                out_d.wr_data = mret_mstatus(mstatus_i);
            end
            TRAP_REDIRECT: begin
                out_d.redirect_valid = 1'b1;
                out_d.redirect_pc    = (state_q == TRAP_MRET_STATUS)
                                     ? {mepc_i[31:2], 2'b00}
                                     : trap_target(mtvec_i, code_d);
            end
            default: ;
        endcase
    end

    assign csr_wr_en_o      = out_q.wr_en;
    assign csr_wr_addr_o    = out_q.wr_addr;
    assign csr_wr_data_o    = out_q.wr_data;
    assign stall_o          = out_q.stall;
    assign flush_o          = out_q.flush;
    assign redirect_valid_o = out_q.redirect_valid;
    assign redirect_pc_o    = out_q.redirect_pc;
    assign busy_o           = out_q.busy;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed table, injected/reset corner cases and
// randomized transactions compared cycle by cycle with a reference model.
module tb_trap_ctrl;
    import proc_pkg::*;

    localparam int NS = 4;

    typedef struct packed {
        logic        wr_en;
        logic [11:0] addr;
        logic [31:0] data;
        logic        stall;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic        busy;
    } obs_t;
    localparam int OW = $bits(obs_t);

    typedef struct packed {
        logic [NS-1:0]       valid;
        logic [NS-1:0][31:0] code;
        logic [NS-1:0][31:0] pc;
        logic [NS-1:0][31:0] tval;
        logic                mret;
        logic [31:0]         mstatus;
        logic [31:0]         mtvec;
        logic [31:0]         mepc;
    } txn_t;

    typedef struct packed {
        txn_t        t;
        logic [2:0]  nwr;
        logic [31:0] e_mepc;
        logic [31:0] e_cause;
        logic [31:0] e_tval;
        logic [31:0] e_mstatus;
        logic [31:0] e_rpc;
    } vec_t;

    localparam int NV = 9;

    logic                clk_i = 1'b0;
    logic                rst_n_i;
    logic [NS-1:0]       exc_valid_i;
    logic [NS-1:0][31:0] exc_code_i, exc_pc_i, exc_tval_i;
    logic                mret_i;
    logic [31:0]         mstatus_i, mtvec_i, mepc_i;
    logic                csr_wr_en_o;
    logic [11:0]         csr_wr_addr_o;
    logic [31:0]         csr_wr_data_o;
    logic                stall_o, flush_o, redirect_valid_o, busy_o;
    logic [31:0]         redirect_pc_o;
    trap_state_t         dbg_state_o;

    logic [OW-1:0] exp_q[$];
    logic [43:0]   obs_wr_q[$];
    logic [31:0]   obs_rpc;
    int            obs_rcyc, obs_fcyc, obs_nflush;
    int            n_tests, n_fail;
    vec_t          tbl[NV];
    string         tname[NV];

    trap_ctrl #(.NUM_SRC(NS)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .exc_valid_i      (exc_valid_i),
        .exc_code_i       (exc_code_i),
        .exc_pc_i         (exc_pc_i),
        .exc_tval_i       (exc_tval_i),
        .mret_i           (mret_i),
        .mstatus_i        (mstatus_i),
        .mtvec_i          (mtvec_i),
        .mepc_i           (mepc_i),
        .csr_wr_en_o      (csr_wr_en_o),
        .csr_wr_addr_o    (csr_wr_addr_o),
        .csr_wr_data_o    (csr_wr_data_o),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .busy_o           (busy_o),
        .dbg_state_o      (dbg_state_o)
    );

    // Clock and watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample();
        obs_t o;
        o.wr_en = csr_wr_en_o;
        o.addr  = csr_wr_addr_o;
        o.data  = csr_wr_data_o;
        o.stall = stall_o;
        o.flush = flush_o;
        o.rv    = redirect_valid_o;
        o.rpc   = redirect_pc_o;
        o.busy  = busy_o;
        return o;
    endfunction

    function automatic obs_t mk(logic we, logic [11:0] a, logic [31:0] d,
                                logic fl, logic rv, logic [31:0] rpc, logic bz);
        obs_t o;
        o.wr_en = we; o.addr = a; o.data = d; o.stall = bz;
        o.flush = fl; o.rv = rv; o.rpc = rpc; o.busy = bz;
        return o;
    endfunction

    task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference model: expected per-cycle outputs after the request edge.
    task automatic model(input txn_t t);
        int idx;
        longint unsigned base, c, tgt;
        logic [31:0] ms;
        idx = -1;
        for (int i = 0; i < NS; i++) begin
            if (t.valid[i] && idx < 0) idx = i;
        end
        exp_q.delete();
        if (idx >= 0) begin
            ms = (t.mstatus & ~32'h88) | (t.mstatus[3] ? 32'h80 : 32'h0) | 32'h1800;
            base = {32'h0, t.mtvec} / 4 * 4;
            c = {32'h0, t.code[idx]};
            if (t.mtvec % 4 == 1 && c >= 64'h8000_0000)
                tgt = (base + 4 * (c - 64'h8000_0000)) % 64'h1_0000_0000;
            else
                tgt = base;
            exp_q.push_back(mk(1, 12'h341, t.pc[idx] / 4 * 4, 1, 0, 0, 1));
            exp_q.push_back(mk(1, 12'h342, t.code[idx], 0, 0, 0, 1));
            exp_q.push_back(mk(1, 12'h343, t.tval[idx], 0, 0, 0, 1));
            exp_q.push_back(mk(1, 12'h300, ms, 0, 0, 0, 1));
            exp_q.push_back(mk(0, 0, 0, 0, 1, 32'(tgt), 1));
        end else if (t.mret) begin
            ms = (t.mstatus & ~32'h8) | (t.mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
            exp_q.push_back(mk(1, 12'h300, ms, 1, 0, 0, 1));
            exp_q.push_back(mk(0, 0, 0, 0, 1, t.mepc / 4 * 4, 1));
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    endtask

    // Driver: applies one transaction at a negedge and scores every cycle
    // until the sequencer is back in IDLE.
    task automatic run_txn(input txn_t t, input bit noise, input int inject_cyc, input string name);
        obs_t        got;
        logic [OW-1:0] e;
        int          cyc;
        model(t);
        obs_wr_q.delete();
        obs_rpc = '0; obs_rcyc = -1; obs_fcyc = -1; obs_nflush = 0;
        exc_valid_i = t.valid; exc_code_i = t.code; exc_pc_i = t.pc; exc_tval_i = t.tval;
        mret_i = t.mret; mstatus_i = t.mstatus; mtvec_i = t.mtvec; mepc_i = t.mepc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk_i);
            cyc++;
            got = sample();
            e = exp_q.pop_front();
            check($sformatf("%s cycle %0d", name, cyc), got, e);
            if (got.wr_en) obs_wr_q.push_back({got.addr, got.data});
            if (got.rv) begin obs_rpc = got.rpc; obs_rcyc = cyc; end
            if (got.flush) begin obs_nflush++; obs_fcyc = cyc; end
            if (exp_q.size() > 0 && (noise || cyc == inject_cyc)) begin
                exc_valid_i = noise ? NS'($urandom_range(0, 2**NS - 1)) : '1;
                mret_i      = noise ? 1'($urandom_range(0, 1)) : 1'b1;
                for (int i = 0; i < NS; i++) begin
                    exc_code_i[i] = $urandom; exc_pc_i[i] = $urandom; exc_tval_i[i] = $urandom;
                end
            end else begin
                exc_valid_i = '0;
                mret_i      = 1'b0;
            end
        end
    endtask

    function automatic txn_t exc1(int src, logic [31:0] code, logic [31:0] pc, logic [31:0] tval,
                                  logic [31:0] ms, logic [31:0] tvec);
        txn_t t;
        t = '0;
        t.valid[src] = 1'b1; t.code[src] = code; t.pc[src] = pc; t.tval[src] = tval;
        t.mstatus = ms; t.mtvec = tvec;
        return t;
    endfunction

    task automatic set_vec(int i, string nm, txn_t t, logic [2:0] nwr, logic [31:0] mepc_w,
                           logic [31:0] cause, logic [31:0] tval, logic [31:0] ms, logic [31:0] rpc);
        tname[i] = nm;
        tbl[i].t = t; tbl[i].nwr = nwr; tbl[i].e_mepc = mepc_w; tbl[i].e_cause = cause;
        tbl[i].e_tval = tval; tbl[i].e_mstatus = ms; tbl[i].e_rpc = rpc;
    endtask

    initial begin
        txn_t        t;
        logic [43:0] ew[$];
        n_tests = 0; n_fail = 0;
        rst_n_i = 1'b0;
        exc_valid_i = '0; exc_code_i = '0; exc_pc_i = '0; exc_tval_i = '0;
        mret_i = 1'b0; mstatus_i = '0; mtvec_i = '0; mepc_i = '0;

        set_vec(0, "single", exc1(2, 32'h2, 32'h1006, 32'hDEAD_BEEF, 32'h8, 32'h100),
                4, 32'h1004, 32'h2, 32'hDEAD_BEEF, 32'h1880, 32'h100);
        t = exc1(1, 32'h5, 32'h2000, 32'h11, 32'h0, 32'h100);
        t.valid[3] = 1'b1; t.code[3] = 32'h7; t.pc[3] = 32'h9990; t.tval[3] = 32'h77;
        set_vec(1, "priority", t, 4, 32'h2000, 32'h5, 32'h11, 32'h1800, 32'h100);
        set_vec(2, "vectored irq", exc1(0, 32'h8000_0007, 32'h3000, 32'h0, 32'h88, 32'h201),
                4, 32'h3000, 32'h8000_0007, 32'h0, 32'h1880, 32'h21C);
        set_vec(3, "vectored exc", exc1(0, 32'h7, 32'h3000, 32'h5, 32'h1800, 32'h201),
                4, 32'h3000, 32'h7, 32'h5, 32'h1800, 32'h200);
        t = '0; t.mret = 1'b1; t.mstatus = 32'h1880; t.mepc = 32'h2003;
        set_vec(4, "mret", t, 1, 0, 0, 0, 32'h1888, 32'h2000);
        t = exc1(0, 32'hB, 32'h4000, 32'h4, 32'hFFFF_FFFF, 32'h8000_0000);
        t.mret = 1'b1; t.mepc = 32'h5555_0000;
        set_vec(5, "exc+mret", t, 4, 32'h4000, 32'hB, 32'h4, 32'hFFFF_FFF7, 32'h8000_0000);
        t = '0; t.mret = 1'b1; t.mstatus = 32'h0; t.mepc = 32'hFFFF_FFFE;
        set_vec(6, "mret mpie0", t, 1, 0, 0, 0, 32'h80, 32'hFFFF_FFFC);
        set_vec(7, "vector wrap", exc1(3, 32'hFFFF_FFFF, 32'h7, 32'h1, 32'h0, 32'h101),
                4, 32'h4, 32'hFFFF_FFFF, 32'h1, 32'h1800, 32'hFC);
        set_vec(8, "mode 3", exc1(1, 32'h8000_0003, 32'h10, 32'h2, 32'h0, 32'h203),
                4, 32'h10, 32'h8000_0003, 32'h2, 32'h1800, 32'h200);

        // Reset
        repeat (3) @(negedge clk_i);
        check("reset outputs", sample(), '0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check("idle after reset", sample(), '0);

        // Directed table
        for (int i = 0; i < NV; i++) begin
            run_txn(tbl[i].t, 1'b0, -1, tname[i]);
            ew.delete();
            if (tbl[i].nwr == 4) begin
                ew.push_back({12'h341, tbl[i].e_mepc});
                ew.push_back({12'h342, tbl[i].e_cause});
                ew.push_back({12'h343, tbl[i].e_tval});
            end
            ew.push_back({12'h300, tbl[i].e_mstatus});
            check({tname[i], " write count"}, OW'(obs_wr_q.size()), OW'(ew.size()));
            for (int j = 0; j < ew.size(); j++)
                check($sformatf("%s write %0d", tname[i], j),
                      (j < obs_wr_q.size()) ? obs_wr_q[j] : 44'h0, ew[j]);
            check({tname[i], " redirect pc"}, obs_rpc, tbl[i].e_rpc);
            check({tname[i], " redirect cycle"}, OW'(obs_rcyc), (tbl[i].nwr == 4) ? OW'(5) : OW'(2));
            check({tname[i], " flush count"}, OW'(obs_nflush), OW'(1));
            check({tname[i], " flush cycle"}, OW'(obs_fcyc), OW'(1));
        end

        // Exception and mret raised during WR_MCAUSE are ignored
        t = exc1(1, 32'h4, 32'h8008, 32'h99, 32'h8, 32'h400);
        run_txn(t, 1'b0, 2, "inject");
        check("inject write count", OW'(obs_wr_q.size()), OW'(4));
        check("inject cause", (obs_wr_q.size() > 1) ? obs_wr_q[1] : 44'h0, {12'h342, 32'h4});

        // Asynchronous reset during WR_MTVAL
        t = exc1(0, 32'h6, 32'h100, 32'h200, 32'h8, 32'h300);
        exc_valid_i = t.valid; exc_code_i = t.code; exc_pc_i = t.pc; exc_tval_i = t.tval;
        mstatus_i = t.mstatus; mtvec_i = t.mtvec;
        @(negedge clk_i);
        exc_valid_i = '0;
        repeat (2) @(negedge clk_i);
        check("mid-seq mtval addr", OW'(csr_wr_addr_o), OW'(CSR_MTVAL));
        #2 rst_n_i = 1'b0;
        #1 check("async reset outputs", sample(), '0);
        @(negedge clk_i);
        check("held reset outputs", sample(), '0);
        rst_n_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check($sformatf("post-reset idle %0d", k), sample(), '0);
        end
        run_txn(t, 1'b0, -1, "after reset");

        // Randomized transactions, back to back, with noise while busy
        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            t = '0;
            for (int i = 0; i < NS; i++) begin
                t.code[i] = $urandom;
                if ($urandom_range(0, 1) == 1) t.code[i][31] = 1'b0;
                t.pc[i] = $urandom; t.tval[i] = $urandom;
            end
            if (kind >= 4) t.valid = NS'($urandom_range(1, 2**NS - 1));
            t.mret    = (kind == 2 || kind == 3 || kind == 4) ? 1'b1 : 1'b0;
            t.mstatus = $urandom; t.mtvec = $urandom; t.mepc = $urandom;
            run_txn(t, 1'($urandom_range(0, 1)), -1, $sformatf("rand %0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
